// File: rtl/register_bank.sv
// 32 x 64-bit integer register file: two combinational read ports and one
// synchronous write port. Register 0 always reads as zero.
module register_bank #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] register1,
  input  logic [ADDR_WIDTH-1:0] register2,
  input  logic [ADDR_WIDTH-1:0] register3,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  regwrite,
  output logic [DATA_WIDTH-1:0] dataout1,
  output logic [DATA_WIDTH-1:0] dataout2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  w_wr_en;
  logic                  w_rd1_zero;
  logic                  w_rd2_zero;

  // Writes to index 0 are dropped here so that entry never leaves its reset value.
  assign w_wr_en = regwrite && (register3 != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[register3] <= datain;
    end
  end

  // Index 0 is forced to zero on the read side as well, so no bypass or
  // pre-reset content can ever leak out of it.
  assign w_rd1_zero = (register1 == '0);
  assign w_rd2_zero = (register2 == '0);

  assign dataout1 = w_rd1_zero ? '0 : r_regs[register1];
  assign dataout2 = w_rd2_zero ? '0 : r_regs[register2];

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus randomized
// traffic compared against an array model of the register file.
module tb_register_bank;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 32;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] register1;
  logic [AW-1:0] register2;
  logic [AW-1:0] register3;
  logic [DW-1:0] datain;
  logic          regwrite;
  logic [DW-1:0] dataout1;
  logic [DW-1:0] dataout2;

  logic [DW-1:0] model [NR];
  logic [DW-1:0] exp_q [$];

  int n_vec;
  int n_err;

  register_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .register1 (register1),
    .register2 (register2),
    .register3 (register3),
    .datain    (datain),
    .regwrite  (regwrite),
    .dataout1  (dataout1),
    .dataout2  (dataout2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    register3 = addr;
    datain    = data;
    regwrite  = 1'b1;
    @(posedge clk);
    #1;
    regwrite  = 1'b0;
    if (rst_n && addr != 0) model[addr] = data;
  endtask

  task automatic set_reads(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    register1 = a1;
    register2 = a2;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    regwrite = 1'b0;
    register1 = '0; register2 = '0; register3 = '0; datain = '0;
    #2 rst_n = 1'b0;
    model_clear();
    set_reads(5'd5, 5'd31);
    n_vec++;
    if (dataout1 !== 64'h0) begin
      n_err++; $display("FAIL reset_rd1 got %h exp %h", dataout1, 64'h0);
    end
    n_vec++;
    if (dataout2 !== 64'h0) begin
      n_err++; $display("FAIL reset_rd2 got %h exp %h", dataout2, 64'h0);
    end
    @(negedge clk);
    register3 = 5'd5;
    datain    = 64'hFFFF_FFFF_FFFF_FFFF;
    regwrite  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    regwrite = 1'b0;
    rst_n = 1'b1;
    set_reads(5'd5, 5'd5);
    n_vec++;
    if (dataout1 !== 64'h0) begin
      n_err++; $display("FAIL reset_write_ignored got %h exp %h", dataout1, 64'h0);
    end
  endtask

  task automatic test_basic();
    drive_write(5'd2, 64'h1234_5678_9ABC_DEF0);
    set_reads(5'd2, 5'd1);
    n_vec++;
    if (dataout1 !== 64'h1234_5678_9ABC_DEF0) begin
      n_err++; $display("FAIL basic_rd1 got %h exp %h", dataout1, 64'h1234_5678_9ABC_DEF0);
    end
    n_vec++;
    if (dataout2 !== 64'h0) begin
      n_err++; $display("FAIL basic_rd2 got %h exp %h", dataout2, 64'h0);
    end
  endtask

  task automatic test_enable_low();
    @(negedge clk);
    regwrite  = 1'b0;
    register3 = 5'd3;
    datain    = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    set_reads(5'd3, 5'd3);
    n_vec++;
    if (dataout1 !== 64'h0) begin
      n_err++; $display("FAIL enable_low got %h exp %h", dataout1, 64'h0);
    end
  endtask

  task automatic test_zero_reg();
    drive_write(5'd0, 64'hAAAA_AAAA_AAAA_AAAA);
    set_reads(5'd0, 5'd0);
    n_vec++;
    if (dataout1 !== 64'h0) begin
      n_err++; $display("FAIL zero_reg_rd1 got %h exp %h", dataout1, 64'h0);
    end
    n_vec++;
    if (dataout2 !== 64'h0) begin
      n_err++; $display("FAIL zero_reg_rd2 got %h exp %h", dataout2, 64'h0);
    end
  endtask

  task automatic test_read_during_write();
    drive_write(5'd7, 64'h1111);
    @(negedge clk);
    register1 = 5'd7;
    register2 = 5'd7;
    register3 = 5'd7;
    datain    = 64'h2222;
    regwrite  = 1'b1;
    #1;
    n_vec++;
    if (dataout1 !== 64'h1111) begin
      n_err++; $display("FAIL rdw_before got %h exp %h", dataout1, 64'h1111);
    end
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    model[7] = 64'h2222;
    n_vec++;
    if (dataout1 !== 64'h2222) begin
      n_err++; $display("FAIL rdw_after got %h exp %h", dataout1, 64'h2222);
    end
    n_vec++;
    if (dataout2 !== 64'h2222) begin
      n_err++; $display("FAIL rdw_same_index got %h exp %h", dataout2, 64'h2222);
    end
  endtask

  task automatic test_sweep();
    logic [DW-1:0] e1, e2;
    for (int i = 1; i < NR; i++) drive_write(AW'(i), {32'hA5A5_A5A5, 32'(i)});
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      set_reads(AW'(i), AW'(31 - i));
      e1 = (i == 0) ? 64'h0 : {32'hA5A5_A5A5, 32'(i)};
      e2 = (i == 31) ? 64'h0 : {32'hA5A5_A5A5, 32'(31 - i)};
      n_vec++;
      if (dataout1 !== e1) begin
        n_err++; $display("FAIL sweep_rd1[%0d] got %h exp %h", i, dataout1, e1);
      end
      n_vec++;
      if (dataout2 !== e2) begin
        n_err++; $display("FAIL sweep_rd2[%0d] got %h exp %h", 31 - i, dataout2, e2);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Reset asserted in the same timestep as a write edge: reset must win.
    @(negedge clk);
    register3 = 5'd4;
    datain    = 64'hCAFE_F00D_CAFE_F00D;
    regwrite  = 1'b1;
    @(posedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < NR; i++) begin
      set_reads(AW'(i), AW'(31 - i));
      n_vec++;
      if (dataout1 !== 64'h0 || dataout2 !== 64'h0) begin
        n_err++;
        $display("FAIL reset_mid[%0d] got %h/%h exp 0/0", i, dataout1, dataout2);
      end
    end
    @(negedge clk);
    regwrite = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [AW-1:0] a1, a2, aw;
    logic [DW-1:0] d;
    logic          we;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      a1 = AW'($urandom_range(0, NR - 1));
      a2 = AW'($urandom_range(0, NR - 1));
      aw = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(0, NR - 1));
      d  = {$urandom, $urandom};
      we = ($urandom_range(0, 2) != 0);
      register1 = a1; register2 = a2; register3 = aw; datain = d; regwrite = we;
      #1;
      exp_q.push_back(model[a1]);
      exp_q.push_back(model[a2]);
      n_vec++;
      if (dataout1 !== exp_q[0]) begin
        n_err++; $display("FAIL rand_pre_rd1 #%0d got %h exp %h", n, dataout1, exp_q[0]);
      end
      n_vec++;
      if (dataout2 !== exp_q[1]) begin
        n_err++; $display("FAIL rand_pre_rd2 #%0d got %h exp %h", n, dataout2, exp_q[1]);
      end
      exp_q.delete();
      @(posedge clk);
      #1;
      if (we && aw != 0) model[aw] = d;
      exp_q.push_back(model[a1]);
      exp_q.push_back(model[a2]);
      n_vec++;
      if (dataout1 !== exp_q[0]) begin
        n_err++; $display("FAIL rand_post_rd1 #%0d got %h exp %h", n, dataout1, exp_q[0]);
      end
      n_vec++;
      if (dataout2 !== exp_q[1]) begin
        n_err++; $display("FAIL rand_post_rd2 #%0d got %h exp %h", n, dataout2, exp_q[1]);
      end
      exp_q.delete();
    end
    regwrite = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_enable_low();
    test_zero_reg();
    test_read_during_write();
    test_sweep();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
